// File: rtl/queue_dispatch_ctrl.sv
// Queue dispatch controller: beam conditioning, counter strobe scheduling and round-robin teller calling.
// Define SERVED_CNT_EN to build the saturating served-customer counter behind served_cnt.

module queue_beam_cond #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic Resetn,
    input  logic raw,
    output logic pass_evt
);

    logic       sync1;
    logic       sync2;
    logic       level;
    logic [3:0] cnt;
    logic       flip;

    // The level flips on the DEB_CYCLES-th consecutive differing sample; a flip towards clear is a pass.
    assign flip     = (sync2 != level) && (cnt == 4'(DEB_CYCLES - 1));
    assign pass_evt = flip && sync2;

    always_ff @(posedge clk) begin
        if (!Resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

module queue_dispatch_ctrl #(
    parameter int N_TELLERS    = 3,
    parameter int ID_W         = 2,
    parameter int DEB_CYCLES   = 4,
    parameter int CALL_TIMEOUT = 200
) (
    input  logic                 clk,
    input  logic                 Resetn,
    input  logic                 back_beam,
    input  logic                 front_beam,
    input  logic                 empty_flag,
    input  logic                 full_flag,
    input  logic [N_TELLERS-1:0] teller_req,
    output logic                 up_count,
    output logic                 down_count,
    output logic [N_TELLERS-1:0] teller_grant,
    output logic                 call_active,
    output logic [ID_W-1:0]      call_id,
    output logic                 served_pulse,
    output logic                 timeout_pulse,
    output logic                 reject_pulse,
    output logic [7:0]           served_cnt
);

    typedef enum logic [1:0] {IDLE, ARB, CALL, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic            back_evt;
    logic            front_evt;
    logic            pend_up;
    logic            pend_dn;
    logic            gap;
    logic            issue_up;
    logic            issue_dn;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] next_ptr;
    logic [ID_W-1:0] arb_idx;
    logic [ID_W:0]   cand;
    logic            arb_found;
    logic [7:0]      timer;
    logic            call_expired;

    queue_beam_cond #(.DEB_CYCLES(DEB_CYCLES)) u_back (
        .clk      (clk),
        .Resetn   (Resetn),
        .raw      (back_beam),
        .pass_evt (back_evt)
    );

    queue_beam_cond #(.DEB_CYCLES(DEB_CYCLES)) u_front (
        .clk      (clk),
        .Resetn   (Resetn),
        .raw      (front_beam),
        .pass_evt (front_evt)
    );

    // Decrements win over increments, and the gap flag forces an idle cycle after every strobe.
    assign issue_dn     = pend_dn && !gap;
    assign issue_up     = pend_up && !pend_dn && !gap;
    assign down_count   = !issue_dn;
    assign up_count     = !issue_up;
    assign reject_pulse = back_evt && full_flag;

    always_ff @(posedge clk) begin
        if (!Resetn) begin
            pend_up <= 1'b0;
            pend_dn <= 1'b0;
            gap     <= 1'b0;
        end else begin
            gap     <= issue_dn || issue_up;
            pend_dn <= issue_dn ? 1'b0 : (pend_dn || (front_evt && !empty_flag));
            pend_up <= issue_up ? 1'b0 : (pend_up || (back_evt && !full_flag));
        end
    end

    // Lowest rotation offset from rr_ptr wins, so scan offsets downwards and keep the last hit.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = N_TELLERS - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(N_TELLERS)) begin
                cand = cand - (ID_W+1)'(N_TELLERS);
            end
            if (teller_req[cand[ID_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign next_ptr     = (call_id == ID_W'(N_TELLERS - 1)) ? '0 : call_id + ID_W'(1);
    assign call_expired = (timer == 8'(CALL_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // In CALL a pass beats a dropped request, which beats the timeout.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (|teller_req && !empty_flag) next_state = ARB;
            ARB:  next_state = arb_found ? CALL : IDLE;
            CALL: begin
                if (front_evt) begin
                    next_state = DONE;
                end else if (!teller_req[call_id] || call_expired) begin
                    next_state = IDLE;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        served_pulse  = (state == DONE);
        timeout_pulse = (state == CALL) && !front_evt && teller_req[call_id] && call_expired;
    end

    always_ff @(posedge clk) begin
        if (!Resetn) begin
            teller_grant <= '0;
            call_active  <= 1'b0;
            call_id      <= '0;
            rr_ptr       <= '0;
            timer        <= '0;
        end else begin
            unique case (state)
                ARB: begin
                    if (arb_found) begin
                        teller_grant <= N_TELLERS'(1) << arb_idx;
                        call_id      <= arb_idx;
                        call_active  <= 1'b1;
                        timer        <= '0;
                    end
                end
                CALL: begin
                    timer <= timer + 8'd1;
                    if (next_state != CALL) begin
                        teller_grant <= '0;
                        call_active  <= 1'b0;
                    end
                    if (timeout_pulse) rr_ptr <= next_ptr;
                end
                DONE: rr_ptr <= next_ptr;
                default: ;
            endcase
        end
    end

`ifdef SERVED_CNT_EN
    logic [7:0] served_q;

    always_ff @(posedge clk) begin
        if (!Resetn) begin
            served_q <= '0;
        end else if (served_pulse && served_q != 8'hFF) begin
            served_q <= served_q + 8'd1;
        end
    end

    assign served_cnt = served_q;
`else
    assign served_cnt = 8'd0;
`endif

endmodule
